de0_uart_rx: RTL and testbench
==============================

// Module: de0_uart_rx
// PURPOSE
//  Serial receive stage behind the DE0 board pin de0_uart_rxd, feeding the vm80a
//  Wishbone bus. It deserialises 8N1 frames and buffers bytes in a FIFO for the CPU.
//  The CPU reads the FIFO through a 2-word Wishbone slave. rx_irq goes to the interrupt logic.
// PARAMETERS
//  BAUD_DIV   868  wb_clk_i cycles per bit (100MHz/115200); legal range 4..65535
//  FIFO_AW    4    FIFO address width; depth = 2**FIFO_AW entries
// PORTS
//  wb_clk_i   in   1   system clock
//  wb_rst_i   in   1   asynchronous reset, active-high
//  wb_adr_i   in   1   0=data register, 1=status register
//  wb_dat_i   in   8   write data (status W1C only)
//  wb_dat_o   out  8   read data, valid while wb_ack_o=1
//  wb_we_i    in   1   1=write cycle
//  wb_stb_i   in   1   strobe/cycle request
//  wb_ack_o   out  1   one-cycle acknowledge
//  uart_rxd   in   1   asynchronous serial input, idle high
//  rx_irq     out  1   high while FIFO not empty
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): rxd synchroniser=11, FSM=IDLE, counters=0,
//   FIFO empty, fe=0, ovr=0, wb_ack_o=0, wb_dat_o=00, rx_irq=0. Any partial frame is discarded.
//  Input: 2-FF synchroniser on uart_rxd; all decisions use the synchronised bit rxs.
//  FSM:
//   IDLE : rxs=0 -> START, bit counter cnt=BAUD_DIV/2-1.
//   START: cnt counts down; at 0 sample: rxs=1 -> IDLE (glitch, nothing recorded);
//          rxs=0 -> DATA, cnt=BAUD_DIV-1, bit index=0.
//   DATA : at cnt=0 sample rxs into shift[idx], LSB first, reload cnt; after idx 7 -> STOP.
//   STOP : at cnt=0 sample: rxs=1 -> push byte; rxs=0 -> fe<=1, no push. Then -> IDLE
//          in the same cycle, so a new start edge is accepted from mid-stop-bit.
//  Push when FIFO full -> byte dropped, ovr<=1, FIFO contents unchanged.
//  FIFO: wr/rd pointers FIFO_AW+1 bits wide, wrap modulo 2**(FIFO_AW+1);
//   empty = ptrs equal; full = MSBs differ and the rest are equal.
//  Wishbone: wb_ack_o <= wb_stb_i & ~wb_ack_o, giving exactly 1 wait state and 1-cycle ack.
//   The next ack needs stb low or the ack-cycle to pass. wb_dat_o is registered with ack and
//   returns to 00 when ack is not asserted.
//   Read adr0: returns FIFO head and pops once, in the cycle ack is set; if empty
//          returns 00 and does not pop.
//   Read adr1: {4'b0, ovr, fe, full, ~empty}.
//   Write adr1: dat[2]=1 clears fe, dat[3]=1 clears ovr. Writes to adr0 are acked and ignored.
//  Simultaneous push+pop: both take effect; when full, no overrun; when empty,
//   the read returns 00 and the byte is stored.
//  Simultaneous flag set (frame) and W1C clear in the same cycle: set wins.
//  rx_irq: registered ~empty, so it lags a push/pop by 1 cycle.
//  Latency: byte visible (~empty) 1 cycle after the stop-bit centre sample.
// TESTING  (BAUD_DIV=8, FIFO_AW=2 in the bench)
//  1 Send frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> rx_irq=1; read adr0 ack'd with
//    wb_dat_o=A5; then status=00, rx_irq=0.
//  2 Send 4 bytes 01..04, then 05 -> status=0B (ovr, full, not empty); reads return
//    01,02,03,04, then 00; write adr1 dat=08 -> status=00.
//  3 Frame 0x3C with stop bit low -> no push, status=04; write adr1 dat=04 -> status=00.
//  4 rxd low pulse of 2 cycles while idle -> FSM returns to IDLE, FIFO stays empty, status=00.
//  5 Assert wb_rst_i during bit 4 of a frame, release, send 0x5A -> only 5A received,
//    fe=0, and all outputs were 0 during reset.
//  6 FIFO full; read adr0 in the same cycle as the stop-bit push of 0x77 -> no ovr; the four
//    reads that follow end with 77.

Source files
------------

// File: rtl/de0_uart_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// de0_uart_rx
//   8N1 serial receiver for the DE0 board UART pin. It deserialises frames,
//   buffers the received bytes in a FIFO and exposes them to the CPU through a
//   two-register Wishbone slave.
//
// Parameters
//   BAUD_DIV  wb_clk_i cycles per serial bit (4..65535)
//   FIFO_AW   FIFO address width; depth = 2**FIFO_AW bytes
//
// Ports
//   wb_clk_i   system clock
//   wb_rst_i   asynchronous reset, active-high
//   wb_adr_i   register select: 0 = data (read pops FIFO), 1 = status
//   wb_dat_i   write data; status bits [2] and [3] are write-1-to-clear
//   wb_dat_o   read data, valid while wb_ack_o=1, otherwise 00
//   wb_we_i    1 = write cycle
//   wb_stb_i   cycle request
//   wb_ack_o   one-cycle acknowledge
//   uart_rxd   asynchronous serial input, idle high
//   rx_irq     high while the FIFO holds data (registered)
//
// Handshake: a request is accepted in the cycle where wb_stb_i=1 and
// wb_ack_o=0; the acknowledge and read data are registered on the next edge
// and last exactly one cycle. Holding wb_stb_i high therefore yields one
// accepted request every second cycle.
//
// Status register: {4'b0, ovr, fe, full, ~empty}
// -----------------------------------------------------------------------------
module de0_uart_rx #(
    parameter int BAUD_DIV = 868,
    parameter int FIFO_AW  = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic       wb_we_i,
    input  logic       wb_stb_i,
    output logic       wb_ack_o,
    input  logic       uart_rxd,
    output logic       rx_irq
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [15:0] HALF_BIT = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_BIT = 16'(BAUD_DIV - 1);

    // Receiver state
    logic             rx_meta;
    logic             rxs;
    logic [1:0]       state;
    logic [15:0]      cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;

    // FIFO state
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [7:0]       mem [DEPTH];
    logic             empty;
    logic             full;

    // Flags and bus-side decode
    logic             fe;
    logic             ovr;
    logic             bit_tick;
    logic             push_req;
    logic             frame_err;
    logic             wb_start;
    logic             rd_pop;
    logic             push_ok;
    logic             overrun;
    logic             clr_fe;
    logic             clr_ovr;
    logic [7:0]       rd_data;
    logic             unused_dat_bits;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

    assign bit_tick  = (cnt == 16'd0);
    assign push_req  = (state == S_STOP) && bit_tick && rxs;
    assign frame_err = (state == S_STOP) && bit_tick && !rxs;

    assign wb_start = wb_stb_i & ~wb_ack_o;
    assign rd_pop   = wb_start & ~wb_we_i & ~wb_adr_i & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign push_ok  = push_req & (~full | rd_pop);
    assign overrun  = push_req & full & ~rd_pop;
    assign clr_fe   = wb_start & wb_we_i & wb_adr_i & wb_dat_i[2];
    assign clr_ovr  = wb_start & wb_we_i & wb_adr_i & wb_dat_i[3];

    assign unused_dat_bits = ^{wb_dat_i[7:4], wb_dat_i[1:0]};

    // 2-FF synchroniser; resets to idle-high so no false start after reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
        end
    end

    // Frame FSM: the start bit is timed to its centre, every later bit is
    // sampled one full bit period after the previous sample.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
            cnt   <= 16'd0;
            idx   <= 3'd0;
            shift <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        cnt   <= HALF_BIT;
                    end
                end
                S_START: begin
                    if (!bit_tick) begin
                        cnt <= cnt - 16'd1;
                    end else if (rxs) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_DATA;
                        cnt   <= FULL_BIT;
                        idx   <= 3'd0;
                    end
                end
                S_DATA: begin
                    if (!bit_tick) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        shift[idx] <= rxs;
                        cnt        <= FULL_BIT;
                        if (idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: begin // S_STOP
                    if (!bit_tick) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        // Back to IDLE at the stop-bit centre so a start edge
                        // arriving in the second half of the stop bit is caught.
                        state <= S_IDLE;
                        cnt   <= 16'd0;
                    end
                end
            endcase
        end
    end

    // FIFO storage carries no reset; only the pointers define its contents.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= shift;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky error flags; a new error outranks a simultaneous clear.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            fe  <= 1'b0;
            ovr <= 1'b0;
        end else begin
            if (frame_err)   fe <= 1'b1;
            else if (clr_fe) fe <= 1'b0;
            if (overrun)      ovr <= 1'b1;
            else if (clr_ovr) ovr <= 1'b0;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (wb_adr_i) begin
            rd_data = {4'b0000, ovr, fe, full, ~empty};
        end else if (!empty) begin
            rd_data = mem[rd_ptr[FIFO_AW-1:0]];
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 8'h00;
            rx_irq   <= 1'b0;
        end else begin
            wb_ack_o <= wb_start;
            wb_dat_o <= (wb_start && !wb_we_i) ? rd_data : 8'h00;
            rx_irq   <= ~empty;
        end
    end

endmodule

// File: tb/tb_de0_uart_rx.sv
`timescale 1ns/1ps
// Directed bench for de0_uart_rx with BAUD_DIV=8 and a 4-entry FIFO.
// All stimulus is applied 1 ns after a rising edge; outputs are sampled at
// the same offset, well away from the active edge.
module tb_de0_uart_rx;

    localparam int BAUD_DIV = 8;
    localparam int FIFO_AW  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_adr;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_we;
    logic       wb_stb;
    logic       wb_ack;
    logic       rxd;
    logic       rx_irq;

    int checks   = 0;
    int failures = 0;

    de0_uart_rx #(
        .BAUD_DIV (BAUD_DIV),
        .FIFO_AW  (FIFO_AW)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (wb_adr),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_we_i  (wb_we),
        .wb_stb_i (wb_stb),
        .wb_ack_o (wb_ack),
        .uart_rxd (rxd),
        .rx_irq   (rx_irq)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line level k cycles after the start edge of a frame (8 cycles per bit).
    function automatic logic frame_bit(input int k, input logic [7:0] d, input logic stop_bit);
        if (k < 8)       return 1'b0;
        else if (k < 72) return d[(k - 8) / 8];
        else if (k < 80) return stop_bit;
        else             return 1'b1;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rxd = frame_bit(0, d, stop_bit);
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            rxd = frame_bit(k, d, stop_bit);
        end
        idle(4);
    endtask

    // Bounded read: lat = number of edges until ack, 0 when no ack came.
    task automatic wb_read(input logic adr, output logic [7:0] d, output int lat);
        wb_adr = adr;
        wb_we  = 1'b0;
        wb_stb = 1'b1;
        d      = 8'hxx;
        lat    = 0;
        for (int i = 1; i <= 4 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (wb_ack === 1'b1) begin
                lat = i;
                d   = wb_dat_o;
            end
        end
        wb_stb = 1'b0;
        idle(1);
    endtask

    task automatic wb_write(input logic adr, input logic [7:0] d, output int lat);
        wb_adr   = adr;
        wb_we    = 1'b1;
        wb_dat_i = d;
        wb_stb   = 1'b1;
        lat      = 0;
        for (int i = 1; i <= 4 && lat == 0; i++) begin
            @(posedge clk);
            #1;
            if (wb_ack === 1'b1) lat = i;
        end
        wb_stb   = 1'b0;
        wb_we    = 1'b0;
        wb_dat_i = 8'h00;
        idle(1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        logic [7:0] d;
        int lat;
        rst      = 1'b1;
        rxd      = 1'b1;
        wb_adr   = 1'b0;
        wb_we    = 1'b0;
        wb_stb   = 1'b0;
        wb_dat_i = 8'h00;
        idle(3);
        checks++;
        if ({wb_ack, wb_dat_o, rx_irq} !== 10'b0) begin
            failures++;
            $display("FAIL reset_outputs: got ack=%b dat=%h irq=%b, need 0/00/0", wb_ack, wb_dat_o, rx_irq);
        end
        rst = 1'b0;
        idle(4);
        wb_read(1'b1, d, lat);
        checks++;
        if (lat != 1 || d !== 8'h00) begin
            failures++;
            $display("FAIL reset_status: got lat=%0d dat=%h, need lat=1 dat=00", lat, d);
        end
    endtask

    task automatic test_single_byte;
        logic [7:0] d;
        int lat;
        send_frame(8'hA5, 1'b1);
        checks++;
        if (rx_irq !== 1'b1) begin
            failures++;
            $display("FAIL a5_irq: got %b, need 1", rx_irq);
        end
        wb_read(1'b0, d, lat);
        checks++;
        if (lat != 1 || d !== 8'hA5) begin
            failures++;
            $display("FAIL a5_data: got lat=%0d dat=%h, need lat=1 dat=a5", lat, d);
        end
        checks++;
        if (wb_dat_o !== 8'h00 || wb_ack !== 1'b0) begin
            failures++;
            $display("FAIL dat_idle: got ack=%b dat=%h, need 0/00", wb_ack, wb_dat_o);
        end
        wb_read(1'b1, d, lat);
        checks++;
        if (lat != 1 || d !== 8'h00) begin
            failures++;
            $display("FAIL a5_status_after: got lat=%0d dat=%h, need 00", lat, d);
        end
        checks++;
        if (rx_irq !== 1'b0) begin
            failures++;
            $display("FAIL a5_irq_after: got %b, need 0", rx_irq);
        end
    endtask

    task automatic test_overrun;
        logic [7:0] d;
        logic [7:0] exp_data [5];
        int lat;
        exp_data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        wb_read(1'b1, d, lat);
        checks++;
        if (d !== 8'h0B) begin
            failures++;
            $display("FAIL ovr_status: got %h, need 0b", d);
        end
        for (int i = 0; i < 5; i++) begin
            wb_read(1'b0, d, lat);
            checks++;
            if (lat != 1 || d !== exp_data[i]) begin
                failures++;
                $display("FAIL ovr_read%0d: got lat=%0d dat=%h, need %h", i, lat, d, exp_data[i]);
            end
        end
        wb_read(1'b1, d, lat);
        checks++;
        if (d !== 8'h08) begin
            failures++;
            $display("FAIL ovr_status_drained: got %h, need 08", d);
        end
        wb_write(1'b1, 8'h08, lat);
        checks++;
        if (lat != 1) begin
            failures++;
            $display("FAIL ovr_w1c_ack: got lat=%0d, need 1", lat);
        end
        wb_read(1'b1, d, lat);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL ovr_cleared: got %h, need 00", d);
        end
    endtask

    task automatic test_frame_error;
        logic [7:0] d;
        int lat;
        send_frame(8'h3C, 1'b0);
        idle(8);
        wb_read(1'b1, d, lat);
        checks++;
        if (d !== 8'h04) begin
            failures++;
            $display("FAIL fe_status: got %h, need 04", d);
        end
        // Writing 1 to the ovr bit alone must leave fe set.
        wb_write(1'b1, 8'h08, lat);
        wb_read(1'b1, d, lat);
        checks++;
        if (d !== 8'h04) begin
            failures++;
            $display("FAIL fe_wrong_clear: got %h, need 04", d);
        end
        wb_write(1'b1, 8'h04, lat);
        wb_read(1'b1, d, lat);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL fe_cleared: got %h, need 00", d);
        end
    endtask

    task automatic test_glitch;
        logic [7:0] d;
        int lat;
        rxd = 1'b0;
        idle(2);
        rxd = 1'b1;
        idle(20);
        wb_read(1'b1, d, lat);
        checks++;
        if (d !== 8'h00 || rx_irq !== 1'b0) begin
            failures++;
            $display("FAIL glitch_status: got status=%h irq=%b, need 00/0", d, rx_irq);
        end
        // Writes to the data register are acknowledged and have no effect.
        wb_write(1'b0, 8'hFF, lat);
        wb_read(1'b1, d, lat);
        checks++;
        if (lat != 1 || d !== 8'h00) begin
            failures++;
            $display("FAIL data_write_ignored: got lat=%0d status=%h, need 1/00", lat, d);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        int lat;
        send_frame(8'h11, 1'b1);
        checks++;
        if (rx_irq !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_irq: got %b, need 1", rx_irq);
        end
        rxd = frame_bit(0, 8'h5A, 1'b1);
        for (int k = 1; k <= 42; k++) begin
            @(posedge clk);
            #1;
            rxd = frame_bit(k, 8'h5A, 1'b1);
        end
        // Middle of bit 4: reset with a bus request pending.
        rst    = 1'b1;
        wb_stb = 1'b1;
        wb_adr = 1'b0;
        rxd    = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({wb_ack, wb_dat_o, rx_irq} !== 10'b0) begin
                failures++;
                $display("FAIL in_reset%0d: got ack=%b dat=%h irq=%b, need 0/00/0", i, wb_ack, wb_dat_o, rx_irq);
            end
            @(posedge clk);
            #1;
        end
        wb_stb = 1'b0;
        rst    = 1'b0;
        idle(16);
        wb_read(1'b1, d, lat);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL post_reset_status: got %h, need 00", d);
        end
        send_frame(8'h5A, 1'b1);
        wb_read(1'b1, d, lat);
        checks++;
        if (d !== 8'h01) begin
            failures++;
            $display("FAIL 5a_status: got %h, need 01", d);
        end
        wb_read(1'b0, d, lat);
        checks++;
        if (d !== 8'h5A) begin
            failures++;
            $display("FAIL 5a_data: got %h, need 5a", d);
        end
        wb_read(1'b1, d, lat);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL 5a_status_after: got %h, need 00", d);
        end
    endtask

    task automatic test_push_pop_full;
        logic [7:0] d;
        logic [7:0] exp_data [4];
        int lat;
        exp_data = '{8'h20, 8'h30, 8'h40, 8'h77};
        send_frame(8'h10, 1'b1);
        send_frame(8'h20, 1'b1);
        send_frame(8'h30, 1'b1);
        send_frame(8'h40, 1'b1);
        // Stop-bit centre sample lands on edge 79 after the start edge; the
        // read request is raised after edge 78 so it is accepted on edge 79.
        rxd = frame_bit(0, 8'h77, 1'b1);
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            #1;
            rxd = frame_bit(k, 8'h77, 1'b1);
            if (k == 78) begin
                wb_adr = 1'b0;
                wb_we  = 1'b0;
                wb_stb = 1'b1;
            end
            if (k == 79) begin
                wb_stb = 1'b0;
                checks++;
                if (wb_ack !== 1'b1 || wb_dat_o !== 8'h10) begin
                    failures++;
                    $display("FAIL pushpop_read: got ack=%b dat=%h, need 1/10", wb_ack, wb_dat_o);
                end
            end
        end
        idle(4);
        wb_read(1'b1, d, lat);
        checks++;
        if (d !== 8'h03) begin
            failures++;
            $display("FAIL pushpop_status: got %h, need 03", d);
        end
        for (int i = 0; i < 4; i++) begin
            wb_read(1'b0, d, lat);
            checks++;
            if (d !== exp_data[i]) begin
                failures++;
                $display("FAIL pushpop_read%0d: got %h, need %h", i, d, exp_data[i]);
            end
        end
        wb_read(1'b1, d, lat);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL pushpop_final_status: got %h, need 00", d);
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_single_byte;
        test_overrun;
        test_frame_error;
        test_glitch;
        test_reset_mid_frame;
        test_push_pop_full;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
